// File: rtl/matvec_sched_if.sv
// Handshake and result-buffer signals between the matrix-vector scheduler,
// the dot-product unit and the result buffer. master = scheduler side.
interface matvec_sched_if #(
  parameter int BITWIDTH = 18,
  parameter int ROW_AW   = 4
);
  logic                       start;
  logic                       abort;
  logic                       peDataReady;
  logic signed [BITWIDTH-1:0] peResult;
  logic [ROW_AW-1:0]          rowAddr;
  logic                       peClear;
  logic                       busy;
  logic                       done;
  logic                       resWe;
  logic [ROW_AW-1:0]          resAddr;
  logic signed [BITWIDTH-1:0] resData;
  logic                       errTimeout;

  modport master (
    input  start, abort, peDataReady, peResult,
    output rowAddr, peClear, busy, done, resWe, resAddr, resData, errTimeout
  );

  modport slave (
    output start, abort, peDataReady, peResult,
    input  rowAddr, peClear, busy, done, resWe, resAddr, resData, errTimeout
  );
endinterface

// File: rtl/matvec_sched.sv
// Row scheduler for a matrix-vector pass: one LOAD/CALC/WRITE round per weight row.
// Optional macro MATVEC_RELU_EN clamps negative results to zero on write.
module matvec_sched #(
  parameter int N_ROWS  = 16,
  parameter int QN      = 6,
  parameter int QM      = 11,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  matvec_sched_if.master bus
);
  localparam int BITWIDTH = QN + QM + 1;
  localparam int ROW_AW   = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int CNT_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_WRITE, S_DONE} state_t;

  state_t                     state_reg, state_next;
  logic [ROW_AW-1:0]          row_reg;
  logic [CNT_W-1:0]           cnt_reg;
  logic signed [BITWIDTH-1:0] cap_reg;
  logic signed [BITWIDTH-1:0] wdata_reg;
  logic [ROW_AW-1:0]          waddr_reg;
  logic                       we_reg;
  logic                       done_reg;
  logic                       err_reg;
  logic [BITWIDTH-1:0]        relu_data;
  logic                       last_row;
  logic                       cnt_expired;

  assign last_row    = (row_reg == ROW_AW'(N_ROWS - 1));
  assign cnt_expired = (cnt_reg == CNT_W'(TIMEOUT - 1));

`ifdef MATVEC_RELU_EN
  for (genvar gi = 0; gi < BITWIDTH; gi++) begin : g_relu
    assign relu_data[gi] = cap_reg[gi] & ~cap_reg[BITWIDTH-1];
  end
`else
  assign relu_data = cap_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bus.start && !bus.abort) state_next = S_LOAD;
      S_LOAD:  state_next = bus.abort ? S_IDLE : S_CALC;
      S_CALC: begin
        if (bus.abort)            state_next = S_IDLE;
        else if (bus.peDataReady) state_next = S_WRITE;
        else if (cnt_expired)     state_next = S_IDLE;
      end
      S_WRITE: begin
        if (bus.abort)     state_next = S_IDLE;
        else if (last_row) state_next = S_DONE;
        else               state_next = S_LOAD;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Write and done strobes are registered off the state they leave, so a reset
  // on that edge suppresses them and an abort can veto the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_reg   <= '0;
      cnt_reg   <= '0;
      cap_reg   <= '0;
      wdata_reg <= '0;
      waddr_reg <= '0;
      we_reg    <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      we_reg   <= (state_reg == S_WRITE);
      done_reg <= (state_reg == S_DONE) && !bus.abort;
      if (state_reg == S_WRITE) begin
        waddr_reg <= row_reg;
        wdata_reg <= relu_data;
      end
      case (state_reg)
        S_IDLE: if (bus.start && !bus.abort) begin
          row_reg <= '0;
          err_reg <= 1'b0;
        end
        S_LOAD: cnt_reg <= '0;
        S_CALC: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (bus.peDataReady) cap_reg <= bus.peResult;
          if (!bus.abort && !bus.peDataReady && cnt_expired) err_reg <= 1'b1;
        end
        S_WRITE: if (!bus.abort && !last_row) row_reg <= row_reg + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy    = (state_reg != S_IDLE);
    bus.peClear = (state_reg != S_CALC);
  end

  assign bus.rowAddr    = row_reg;
  assign bus.done       = done_reg;
  assign bus.resWe      = we_reg;
  assign bus.resAddr    = waddr_reg;
  assign bus.resData    = wdata_reg;
  assign bus.errTimeout = err_reg;
endmodule

// File: tb/tb_matvec_sched.sv
// Directed/randomized bench for matvec_sched with a dot-product stub and a
// latency/result model derived from the per-row cycle budget LOAD + k + WRITE.
module tb_matvec_sched;
  localparam int N  = 4;
  localparam int BW = 18;
  localparam int AW = 2;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  matvec_sched_if #(.BITWIDTH(BW), .ROW_AW(AW)) bus ();
  matvec_sched #(.N_ROWS(N), .QN(6), .QM(11), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int k_arr[N];
  logic [BW-1:0] v_arr[N];
  int s[N+1];
  int calc_cnt = 0;
  int wr_addr_q[$];
  int wr_off_q[$];
  logic [BW-1:0] wr_data_q[$];
  int done_q[$];
  int err_off;
  bit busy_at[128];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] exp_data(logic [BW-1:0] v);
`ifdef MATVEC_RELU_EN
    return v[BW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Stub: result valid on the k-th CALC cycle of a row (k=0: never); noise elsewhere.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.peClear === 1'b0) begin
      calc_cnt++;
      bus.peDataReady = (calc_cnt == k_arr[bus.rowAddr]);
      bus.peResult    = v_arr[bus.rowAddr];
    end else begin
      calc_cnt = 0;
      bus.peDataReady = 1'($urandom_range(0, 1));
      bus.peResult    = BW'($urandom);
    end
  endtask

  task automatic calc_s();
    s[0] = 0;
    for (int r = 0; r < N; r++) s[r+1] = s[r] + 2 + k_arr[r];
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_rowAddr"}, 32'(bus.rowAddr), 0);
    check({tag, "_peClear"}, 32'(bus.peClear), 1);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_resWe"}, 32'(bus.resWe), 0);
    check({tag, "_resAddr"}, 32'(bus.resAddr), 0);
    check({tag, "_resData"}, 32'(bus.resData), 0);
    check({tag, "_errTimeout"}, 32'(bus.errTimeout), 0);
  endtask

  task automatic start_pass(bit hold);
    wr_addr_q.delete(); wr_off_q.delete(); wr_data_q.delete(); done_q.delete();
    err_off = -1;
    bus.start = 1'b1;
    tick();
    if (!hold) bus.start = 1'b0;
  endtask

  // Offset 0 is the cycle after start is sampled; every wait is a fixed cycle count.
  task automatic observe(int ncyc, int abort_at, int reset_at);
    for (int off = 1; off <= ncyc; off++) begin
      bus.abort = (off - 1 == abort_at);
      reset     = (off - 1 == reset_at);
      tick();
      busy_at[off] = bus.busy;
      if (bus.resWe === 1'b1) begin
        wr_addr_q.push_back(int'(bus.resAddr));
        wr_data_q.push_back(bus.resData);
        wr_off_q.push_back(off);
      end
      if (bus.done === 1'b1) begin
        done_q.push_back(off);
        bus.start = 1'b0;
      end
      if (bus.errTimeout === 1'b1 && err_off < 0) err_off = off;
      if (off - 1 == reset_at) check_reset_outputs("midpass_reset");
    end
    bus.abort = 1'b0;
    reset = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic check_writes(string tag, int nexp);
    check({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(nexp));
    for (int i = 0; i < nexp && i < wr_addr_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[i]), 32'(i));
      check($sformatf("%s_data%0d", tag, i), 32'(wr_data_q[i]), 32'(exp_data(v_arr[i])));
      check($sformatf("%s_off%0d", tag, i), 32'(wr_off_q[i]), 32'(s[i+1]));
    end
    $display("pass %s: writes=%0d done=%0d err_off=%0d", tag, wr_addr_q.size(), done_q.size(), err_off);
  endtask

  task automatic set_rows(int k0, int k1, int k2, int k3);
    k_arr[0] = k0; k_arr[1] = k1; k_arr[2] = k2; k_arr[3] = k3;
    for (int r = 0; r < N; r++) v_arr[r] = BW'($urandom);
    calc_s();
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.peDataReady = 1'b0; bus.peResult = '0;
    for (int r = 0; r < N; r++) begin k_arr[r] = 3; v_arr[r] = '0; end
    reset = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Nominal pass, k=3 on every row: done lands 21 cycles after start is sampled.
    set_rows(3, 3, 3, 3);
    v_arr[0] = 18'h00800; v_arr[1] = 18'h3F800;
    start_pass(0);
    check("nominal_busy_load", 32'(bus.busy), 1);
    check("nominal_peClear_load", 32'(bus.peClear), 1);
    observe(s[N] + 4, -1, -1);
    check_writes("nominal", N);
    check("nominal_done_cnt", 32'(done_q.size()), 1);
    if (done_q.size() > 0) check("nominal_done_off", 32'(done_q[0]), 21);
    check("nominal_busy_in_done", 32'(busy_at[s[N]]), 1);
    check("nominal_busy_after", 32'(busy_at[s[N]+1]), 0);
    check("nominal_rowaddr_hold", 32'(bus.rowAddr), N - 1);

    // Randomized row latencies, including the 15-cycle boundary on one row.
    for (int p = 0; p < 4; p++) begin
      set_rows($urandom_range(1, TO), $urandom_range(1, TO), (p == 0) ? TO : $urandom_range(1, TO), 1);
      start_pass(0);
      observe(s[N] + 4, -1, -1);
      check_writes($sformatf("rand%0d", p), N);
      check($sformatf("rand%0d_done_cnt", p), 32'(done_q.size()), 1);
      if (done_q.size() > 0) check($sformatf("rand%0d_done_off", p), 32'(done_q[0]), 32'(s[N] + 1));
      check($sformatf("rand%0d_err", p), 32'(err_off), 32'(-1));
    end

    // Row 1 never answers: timeout after TO CALC cycles, no further writes, no done.
    set_rows(2, 0, 2, 2);
    start_pass(0);
    observe(s[1] + TO + 5, -1, -1);
    check_writes("timeout", 1);
    check("timeout_err_off", 32'(err_off), 32'(s[1] + 1 + TO));
    check("timeout_busy_before", 32'(busy_at[s[1] + TO]), 1);
    check("timeout_busy_after", 32'(busy_at[s[1] + 1 + TO]), 0);
    check("timeout_no_done", 32'(done_q.size()), 0);

    // Abort on the 2nd CALC cycle of row 2; sticky error cleared by the new start.
    check("err_sticky", 32'(bus.errTimeout), 1);
    set_rows(4, 4, 4, 4);
    start_pass(0);
    check("err_cleared", 32'(bus.errTimeout), 0);
    observe(s[N] + 4, s[2] + 2, -1);
    check_writes("abort_calc", 2);
    check("abort_calc_busy", 32'(busy_at[s[2] + 3]), 0);
    check("abort_calc_no_done", 32'(done_q.size()), 0);

    // Restart after abort begins at row 0.
    set_rows(1, 2, 3, 4);
    start_pass(0);
    observe(s[N] + 4, -1, -1);
    check_writes("restart", N);
    check("restart_done_cnt", 32'(done_q.size()), 1);

    // Abort during WRITE of the last row still writes; abort during DONE kills done.
    set_rows(2, 3, 2, 3);
    start_pass(0);
    observe(s[N] + 4, s[N] - 1, -1);
    check_writes("abort_lastwrite", N);
    check("abort_lastwrite_no_done", 32'(done_q.size()), 0);
    start_pass(0);
    observe(s[N] + 4, s[N], -1);
    check_writes("abort_done", N);
    check("abort_done_no_done", 32'(done_q.size()), 0);

    // Reset during WRITE of row 1: that write never appears.
    set_rows(3, 2, 3, 3);
    start_pass(0);
    observe(s[N] + 4, -1, s[2] - 1);
    check_writes("reset_write", 1);
    check("reset_write_no_done", 32'(done_q.size()), 0);

    // start and abort together in IDLE: stays idle.
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    check("start_abort_busy0", 32'(bus.busy), 0);
    tick();
    check("start_abort_busy1", 32'(bus.busy), 0);
    bus.start = 1'b0; bus.abort = 1'b0;
    tick();

    // start held through a pass: exactly one pass, then idle once start drops.
    set_rows(2, 1, 3, 2);
    start_pass(1);
    observe(s[N] + 4, -1, -1);
    check_writes("held_start", N);
    check("held_done_cnt", 32'(done_q.size()), 1);
    if (done_q.size() > 0) check("held_done_off", 32'(done_q[0]), 32'(s[N] + 1));
    check("held_busy_after", 32'(busy_at[s[N] + 2]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/matvec_sched.md
MATVEC_SCHED -- requirements
Module: matvec_sched

Interface
REQ-001 Parameter N_ROWS, default 16: number of weight rows, one dot product each.
REQ-002 Parameter QN, default 6: integer bits of the fixed-point format.
REQ-003 Parameter QM, default 11: fractional bits; BITWIDTH = QN+QM+1; ROW_AW = ceil(log2(N_ROWS)), minimum 1.
REQ-004 Parameter TIMEOUT, default 15: maximum CALC cycles waited per row.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 start  in  1  begin a matrix-vector pass; sampled only in IDLE.
REQ-008 abort  in  1  terminate the pass in progress.
REQ-009 peDataReady  in  1  dot-product unit result valid.
REQ-010 peResult  in  BITWIDTH  signed dot-product result.
REQ-011 rowAddr  out  ROW_AW  weight-memory row address.
REQ-012 peClear  out  1  clears the dot-product accumulator and sequencer.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pass-complete pulse.
REQ-015 resWe  out  1  result-buffer write enable.
REQ-016 resAddr  out  ROW_AW  result-buffer write address.
REQ-017 resData  out  BITWIDTH  signed result-buffer write data.
REQ-018 errTimeout  out  1  sticky timeout flag.

Function
REQ-019 FSM states: IDLE, LOAD, CALC, WRITE, DONE; all outputs registered or decoded from registered state only.
REQ-020 IDLE: start=1 and abort=0 -> LOAD, rowAddr=0, errTimeout cleared; start while busy ignored.
REQ-021 LOAD: exactly one cycle, peClear=1 (covers weight-memory read latency); peDataReady ignored; -> CALC.
REQ-022 CALC: peClear=0, per-row wait counter increments each cycle; peDataReady=1 -> capture peResult, -> WRITE.
REQ-023 CALC: counter reaching TIMEOUT without peDataReady -> errTimeout=1, -> IDLE, no write, no done.
REQ-024 WRITE: resWe=1 for one cycle, resAddr=rowAddr, resData=captured value.
REQ-025 WRITE: rowAddr==N_ROWS-1 -> DONE; else rowAddr increments, -> LOAD.
REQ-026 DONE: done=1 one cycle, -> IDLE; rowAddr holds N_ROWS-1 until next start.
REQ-027 Per-row latency = 1 (LOAD) + k (CALC cycles until peDataReady, including the ready cycle) + 1 (WRITE).
REQ-028 abort=1 in LOAD/CALC/WRITE/DONE -> IDLE next edge; a WRITE cycle coinciding with abort still writes; done suppressed if abort coincides with DONE.
REQ-029 abort and start same cycle in IDLE: abort wins, stay IDLE.
REQ-030 peDataReady outside CALC has no effect.

Reset
REQ-031 reset=1 -> IDLE; rowAddr=0, peClear=1, busy=0, done=0, resWe=0, resAddr=0, resData=0, errTimeout=0, wait counter=0.
REQ-032 reset mid-pass takes priority over all inputs; no write or done in that cycle.

Configuration
REQ-033 Macro MATVEC_RELU_EN defined: resData = 0 when captured result is negative, else the result (ReLU applied at WRITE).
REQ-034 MATVEC_RELU_EN undefined: resData = captured peResult unmodified.

Verification
REQ-035 N_ROWS=4, stub asserts peDataReady on 3rd CALC cycle, start pulse -> resWe at addresses 0,1,2,3, done 21 cycles after start sampled.
REQ-036 Stub results 18'sh00800, 18'sh3F800 -> resData 0x00800, 0x3F800 (ReLU off) / 0x00800, 0x00000 (MATVEC_RELU_EN).
REQ-037 Stub never asserts peDataReady, TIMEOUT=15 -> errTimeout=1 after 15 CALC cycles, back to IDLE, no resWe, no done.
REQ-038 abort during CALC of row 2 -> IDLE next cycle, rows 0,1 written only, no done; subsequent start restarts at row 0.
REQ-039 start held high throughout pass -> single pass per start sampled in IDLE; start and abort both high in IDLE -> stays IDLE.
REQ-040 reset asserted during WRITE of row 1 -> no write that cycle, all outputs at REQ-031 values next cycle.
